frame_pixel_accumulator: RTL and testbench

- Downstream consumer of the 30-frame x 8-pixel frame buffer RAM (`ram4x4`).
- On `start`, it walks the buffer pixel-major: for each pixel index 0..7 it reads that pixel from every frame 0..NUM_FRAMES-1.
- It accumulates the 10-bit samples into a per-pixel sum and checks that the stored 4-bit pixel address tag is identical in every frame.
- It emits one result per pixel on a valid/ready stream to the THz image post-processing stage.

---
 rtl/frame_pixel_accumulator.sv | 241 ++++++++++++++++++++++++
 tb/tb_frame_pixel_accumulator.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_accumulator.sv
// ---------------------------------------------------------------------------
// frame_pixel_accumulator
//
// Purpose:
//   Reads a multi-frame pixel buffer pixel-major. For each pixel index p it
//   reads that pixel from frames 0..NUM_FRAMES-1 and sums the samples. It
//   also checks that the address tag stored with the pixel is the same in
//   every frame. One result per pixel is then sent on a valid/ready stream.
//
// Ports:
//   clk, rst            system clock (rising edge), synchronous active-high reset
//   start               single-cycle scan request (ignored while busy)
//   busy                high while a scan is in progress
//   done                one-cycle pulse after the last result is accepted
//   rd_timeout_err      one-cycle pulse when a read never returns; scan aborted
//   ram_read_en         one-cycle read request to the frame buffer
//   ram_frame_sel       frame index of the request
//   ram_pixel_index     pixel index of the request
//   ram_pixel_data      returned sample
//   ram_pixel_addr      returned address tag
//   ram_valid           returned data valid (only honoured while waiting)
//   out_valid/out_ready result handshake
//   out_sum             sum of the pixel over all frames
//   out_pixel_index     pixel index of the result
//   out_pixel_addr      tag captured from frame 0
//   out_tag_err         tag differed in at least one frame
// ---------------------------------------------------------------------------
module frame_pixel_accumulator #(
    parameter int NUM_FRAMES    = 30,
    parameter int PIX_PER_FRAME = 8,
    parameter int DATA_W        = 10,
    parameter int SUM_W         = 15,
    parameter int RD_TIMEOUT    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_timeout_err,
    output logic              ram_read_en,
    output logic [4:0]        ram_frame_sel,
    output logic [2:0]        ram_pixel_index,
    input  logic [DATA_W-1:0] ram_pixel_data,
    input  logic [3:0]        ram_pixel_addr,
    input  logic              ram_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [2:0]        out_pixel_index,
    output logic [3:0]        out_pixel_addr,
    output logic              out_tag_err
);

    // Wait counter must be able to hold RD_TIMEOUT-1.
    localparam int WAIT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    localparam logic [4:0]        F_LAST = 5'(NUM_FRAMES - 1);
    localparam logic [2:0]        P_LAST = 3'(PIX_PER_FRAME - 1);
    localparam logic [WAIT_W-1:0] W_LAST = WAIT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [4:0]        f_q, f_d;
    logic [2:0]        p_q, p_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [3:0]        tag_q, tag_d;
    logic              err_q, err_d;

    // Decoded events shared by the FSM and the datapath.
    logic rd_hit;
    logic wait_expired;
    logic accept;
    logic last_frame;
    logic last_pix;

    assign rd_hit       = (state_q == S_WAIT) && ram_valid;
    assign wait_expired = (state_q == S_WAIT) && !ram_valid && (wait_q == W_LAST);
    assign accept       = (state_q == S_OUT) && out_ready;
    assign last_frame   = (f_q == F_LAST);
    assign last_pix     = (p_q == P_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rd_hit) begin
                    state_d = last_frame ? S_OUT : S_ISSUE;
                end else if (wait_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_OUT: begin
                if (accept) begin
                    state_d = last_pix ? S_DONE : S_ISSUE;
                end
            end
            // Extra cycle so done pulses while busy is still high; a start
            // arriving here is therefore ignored.
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (payloads are zero whenever their strobe is low)
    // -----------------------------------------------------------------------
    always_comb begin
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_DONE);
        rd_timeout_err  = wait_expired;
        ram_read_en     = (state_q == S_ISSUE);
        ram_frame_sel   = '0;
        ram_pixel_index = '0;
        out_valid       = (state_q == S_OUT);
        out_sum         = '0;
        out_pixel_index = '0;
        out_pixel_addr  = '0;
        out_tag_err     = 1'b0;
        if (state_q == S_ISSUE) begin
            ram_frame_sel   = f_q;
            ram_pixel_index = p_q;
        end
        if (state_q == S_OUT) begin
            out_sum         = acc_q;
            out_pixel_index = p_q;
            out_pixel_addr  = tag_q;
            out_tag_err     = err_q;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath next-state
    // -----------------------------------------------------------------------
    always_comb begin
        f_d    = f_q;
        p_d    = p_q;
        wait_d = wait_q;
        acc_d  = acc_q;
        tag_d  = tag_q;
        err_d  = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    f_d   = '0;
                    p_d   = '0;
                    acc_d = '0;
                    err_d = 1'b0;
                end
            end
            S_ISSUE: begin
                wait_d = '0;
            end
            S_WAIT: begin
                if (ram_valid) begin
                    acc_d = acc_q + {{(SUM_W - DATA_W){1'b0}}, ram_pixel_data};
                    // Frame 0 defines the reference tag for this pixel.
                    if (f_q == 5'd0) begin
                        tag_d = ram_pixel_addr;
                    end else if (ram_pixel_addr != tag_q) begin
                        err_d = 1'b1;
                    end
                    if (!last_frame) begin
                        f_d = f_q + 5'd1;
                    end
                end else if (!wait_expired) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    acc_d = '0;
                    err_d = 1'b0;
                    f_d   = '0;
                    if (!last_pix) begin
                        p_d = p_q + 3'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q    <= '0;
            p_q    <= '0;
            wait_q <= '0;
            acc_q  <= '0;
            tag_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            f_q    <= f_d;
            p_q    <= p_d;
            wait_q <= wait_d;
            acc_q  <= acc_d;
            tag_q  <= tag_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_frame_pixel_accumulator.sv
`timescale 1ns/1ps
module tb_frame_pixel_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_timeout_err;
    logic        ram_read_en;
    logic [4:0]  ram_frame_sel;
    logic [2:0]  ram_pixel_index;
    logic [9:0]  ram_pixel_data;
    logic [3:0]  ram_pixel_addr;
    logic        ram_valid;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_sum;
    logic [2:0]  out_pixel_index;
    logic [3:0]  out_pixel_addr;
    logic        out_tag_err;

    always #5 clk = ~clk;

    frame_pixel_accumulator dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .rd_timeout_err  (rd_timeout_err),
        .ram_read_en     (ram_read_en),
        .ram_frame_sel   (ram_frame_sel),
        .ram_pixel_index (ram_pixel_index),
        .ram_pixel_data  (ram_pixel_data),
        .ram_pixel_addr  (ram_pixel_addr),
        .ram_valid       (ram_valid),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sum         (out_sum),
        .out_pixel_index (out_pixel_index),
        .out_pixel_addr  (out_pixel_addr),
        .out_tag_err     (out_tag_err)
    );

    // ------------------------------------------------------------------
    // Frame buffer stub: data returns 2 cycles after the request cycle.
    // Requests to kill_frame never return.
    // ------------------------------------------------------------------
    logic [9:0] mem_data [32][8];
    logic [3:0] mem_tag  [32][8];
    int         kill_frame = -1;
    logic       v1, v2;
    logic [9:0] d1, d2;
    logic [3:0] t1, t2;

    always @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= ram_read_en && (int'(ram_frame_sel) != kill_frame);
            d1 <= mem_data[ram_frame_sel][ram_pixel_index];
            t1 <= mem_tag[ram_frame_sel][ram_pixel_index];
            v2 <= v1;
            d2 <= d1;
            t2 <= t1;
        end
    end
    assign ram_valid      = v2;
    assign ram_pixel_data = d2;
    assign ram_pixel_addr = t2;

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int              pattern;     // 0: 10p+f/tag p+4, 1: 1023/tag p+4, 2: tag fault
        int              stall_pix;   // pixel to hold out_ready low for 20 cycles, -1 none
        bit              start_on_done;
        bit              start_mid;   // pulse start during the scan (must be ignored)
        logic [7:0][14:0] exp_sum;
        logic [7:0][3:0]  exp_addr;
        logic [7:0]       exp_err;
    } vec_t;

    vec_t vecs [4];

    logic [14:0] res_sum  [8];
    logic [3:0]  res_addr [8];
    logic        res_err  [8];
    logic [2:0]  res_idx  [8];
    int n_res, n_done, n_to, gap_bad, order_bad, stall_bad, stall_seen, post_req;
    logic busy_after;

    task automatic fill(input int pattern);
        for (int f = 0; f < 32; f++) begin
            for (int p = 0; p < 8; p++) begin
                case (pattern)
                    1: begin
                        mem_data[f][p] = 10'd1023;
                        mem_tag[f][p]  = 4'(p + 4);
                    end
                    2: begin
                        mem_data[f][p] = 10'(10 * p + f);
                        mem_tag[f][p]  = (f == 17 && p == 3) ? 4'hF : 4'h3;
                    end
                    default: begin
                        mem_data[f][p] = 10'(10 * p + f);
                        mem_tag[f][p]  = 4'(p + 4);
                    end
                endcase
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},       int'(busy), 0);
        check({tag, "_done"},       int'(done), 0);
        check({tag, "_timeout"},    int'(rd_timeout_err), 0);
        check({tag, "_read_en"},    int'(ram_read_en), 0);
        check({tag, "_frame_sel"},  int'(ram_frame_sel), 0);
        check({tag, "_pix_index"},  int'(ram_pixel_index), 0);
        check({tag, "_out_valid"},  int'(out_valid), 0);
        check({tag, "_out_sum"},    int'(out_sum), 0);
        check({tag, "_out_pix"},    int'(out_pixel_index), 0);
        check({tag, "_out_addr"},   int'(out_pixel_addr), 0);
        check({tag, "_out_tagerr"}, int'(out_tag_err), 0);
    endtask

    // Runs one full scan from a start pulse; called at a negedge.
    task automatic run_scan(input int stall_pix, input bit start_on_done, input bit start_mid);
        int last_req, exp_f, exp_p, stall_left, after_done;
        logic [14:0] s_sum;
        logic [3:0]  s_addr;
        logic [2:0]  s_idx;
        logic        s_err;
        n_res = 0; n_done = 0; n_to = 0; gap_bad = 0; order_bad = 0;
        stall_bad = 0; stall_seen = 0; post_req = 0; busy_after = 1'bx;
        last_req = -1; exp_f = 0; exp_p = 0; stall_left = 0; after_done = -1;
        s_sum = '0; s_addr = '0; s_idx = '0; s_err = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (ram_read_en) begin
                if (after_done >= 0) post_req++;
                if (ram_frame_sel != 5'd0 && c - last_req != 3) gap_bad++;
                if (int'(ram_frame_sel) != exp_f || int'(ram_pixel_index) != exp_p) order_bad++;
                if (start_mid && ram_pixel_index == 3'd1 && ram_frame_sel == 5'd0) start = 1'b1;
                last_req = c;
                exp_f++;
                if (exp_f == 30) begin
                    exp_f = 0;
                    exp_p++;
                end
            end
            if (out_valid && int'(out_pixel_index) == stall_pix && stall_seen == 0) begin
                stall_seen = 1;
                stall_left = 20;
                s_sum = out_sum; s_addr = out_pixel_addr; s_idx = out_pixel_index; s_err = out_tag_err;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                if (!out_valid || ram_read_en || out_sum != s_sum || out_pixel_addr != s_addr ||
                    out_pixel_index != s_idx || out_tag_err != s_err) stall_bad++;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (n_res < 8) begin
                    res_sum[n_res]  = out_sum;
                    res_addr[n_res] = out_pixel_addr;
                    res_err[n_res]  = out_tag_err;
                    res_idx[n_res]  = out_pixel_index;
                end
                $display("[TB] result pix=%0d sum=%0d addr=%0d tag_err=%0b",
                         out_pixel_index, out_sum, out_pixel_addr, out_tag_err);
                n_res++;
            end
            if (rd_timeout_err) n_to++;
            if (done) begin
                n_done++;
                if (after_done < 0) after_done = 0;
                if (start_on_done) start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            if (after_done >= 0) begin
                after_done++;
                if (after_done == 1) busy_after = busy;
                if (after_done >= 6) break;
            end
        end
    endtask

    task automatic check_vec(input int v, input string tag);
        check({tag, "_n_results"}, n_res, 8);
        for (int p = 0; p < 8; p++) begin
            if (p < n_res) begin
                check($sformatf("%s_idx%0d", tag, p),  int'(res_idx[p]), p);
                check($sformatf("%s_sum%0d", tag, p),  int'(res_sum[p]), int'(vecs[v].exp_sum[p]));
                check($sformatf("%s_addr%0d", tag, p), int'(res_addr[p]), int'(vecs[v].exp_addr[p]));
                check($sformatf("%s_err%0d", tag, p),  int'(res_err[p]), int'(vecs[v].exp_err[p]));
            end
        end
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_busy_after_done"}, int'(busy_after), 0);
        check({tag, "_req_spacing"}, gap_bad, 0);
        check({tag, "_req_order"}, order_bad, 0);
        check({tag, "_req_after_done"}, post_req, 0);
        check({tag, "_no_timeout"}, n_to, 0);
        if (vecs[v].stall_pix >= 0) begin
            check({tag, "_stall_seen"}, stall_seen, 1);
            check({tag, "_stall_stable"}, stall_bad, 0);
        end
    endtask

    initial begin
        int req_c, to_c, n_ov, found;

        // Expected results, hand-computed: sum = sum_f(10p+f) = 300p+435.
        vecs[0].pattern = 0; vecs[0].stall_pix = -1; vecs[0].start_on_done = 0; vecs[0].start_mid = 0;
        vecs[0].exp_sum  = {15'd2535, 15'd2235, 15'd1935, 15'd1635, 15'd1335, 15'd1035, 15'd735, 15'd435};
        vecs[0].exp_addr = {4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
        vecs[0].exp_err  = 8'h00;

        vecs[1].pattern = 1; vecs[1].stall_pix = -1; vecs[1].start_on_done = 1; vecs[1].start_mid = 0;
        vecs[1].exp_sum  = {8{15'd30690}};
        vecs[1].exp_addr = {4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
        vecs[1].exp_err  = 8'h00;

        vecs[2].pattern = 2; vecs[2].stall_pix = -1; vecs[2].start_on_done = 0; vecs[2].start_mid = 1;
        vecs[2].exp_sum  = {15'd2535, 15'd2235, 15'd1935, 15'd1635, 15'd1335, 15'd1035, 15'd735, 15'd435};
        vecs[2].exp_addr = {8{4'd3}};
        vecs[2].exp_err  = 8'h08;

        vecs[3].pattern = 0; vecs[3].stall_pix = 2; vecs[3].start_on_done = 0; vecs[3].start_mid = 0;
        vecs[3].exp_sum  = {15'd2535, 15'd2235, 15'd1935, 15'd1635, 15'd1335, 15'd1035, 15'd735, 15'd435};
        vecs[3].exp_addr = {4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
        vecs[3].exp_err  = 8'h00;

        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        fill(0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table-driven scans
        for (int v = 0; v < 4; v++) begin
            fill(vecs[v].pattern);
            run_scan(vecs[v].stall_pix, vecs[v].start_on_done, vecs[v].start_mid);
            check_vec(v, $sformatf("vec%0d", v));
            repeat (3) @(negedge clk);
        end

        // Read timeout at frame 5 of pixel 0
        fill(0);
        kill_frame = 5;
        req_c = -1; to_c = -1; n_to = 0; n_done = 0; n_ov = 0; post_req = 0; busy_after = 1'bx;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (ram_read_en && ram_frame_sel == 5'd5) req_c = c;
            if (ram_read_en && to_c >= 0) post_req++;
            if (rd_timeout_err) begin
                n_to++;
                to_c = c;
            end
            if (done) n_done++;
            if (out_valid) n_ov++;
            @(negedge clk);
            if (to_c >= 0 && c == to_c) busy_after = busy;
            if (to_c >= 0 && c >= to_c + 20) break;
        end
        $display("[TB] timeout request_cycle=%0d pulse_cycle=%0d", req_c, to_c);
        check("timeout_pulse_count", n_to, 1);
        check("timeout_latency", to_c - req_c, 8);
        check("timeout_busy_after", int'(busy_after), 0);
        check("timeout_no_done", n_done, 0);
        check("timeout_no_out_valid", n_ov, 0);
        check("timeout_no_more_reads", post_req, 0);
        kill_frame = -1;
        repeat (3) @(negedge clk);

        // Reset during the WAIT of pixel 4, then a fresh scan
        fill(0);
        found = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (ram_read_en && ram_pixel_index == 3'd4 && ram_frame_sel == 5'd10) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("midreset_reached_pixel4", found, 1);
        @(negedge clk);
        check("midreset_in_wait_busy", int'(busy), 1);
        check("midreset_in_wait_no_read", int'(ram_read_en), 0);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset_idle_stays", int'(busy), 0);
        run_scan(-1, 1'b0, 1'b0);
        check_vec(0, "rerun");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
